// File: rtl/fifo_pkg.sv
// Shared definitions for the delay FIFO and its read-side snapshot streamer.
package fifo_pkg;

   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned FIFO_BITS  = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } fifo_reader_state_t;

endpackage : fifo_pkg

// File: rtl/fifo_reader.sv
// fifo_reader: captures a DEPTH x BITS snapshot in one cycle, then streams it
// oldest-first over valid/ready and pulses done after the last beat.
// Optional feature: define FIFO_READER_PARITY_EN to add the out_parity port.
module fifo_reader
   import fifo_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH,
   parameter int unsigned BITS  = FIFO_BITS
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        load,
   input  logic [DEPTH*BITS-1:0]       load_data,
   input  logic                        flush,
   output logic                        busy,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [BITS-1:0]             out_data,
   output logic [$clog2(DEPTH)-1:0]    out_idx,
   output logic                        out_last,
   output logic                        done
`ifdef FIFO_READER_PARITY_EN
   ,
   output logic                        out_parity
`endif
);

   localparam int unsigned      IDX_W    = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   fifo_reader_state_t state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [BITS-1:0]    snap_q [DEPTH];
   logic [BITS-1:0]    snap_d [DEPTH];

   logic               busy_q, busy_d;
   logic               out_valid_q, out_valid_d;
   logic [BITS-1:0]    out_data_q, out_data_d;
   logic [IDX_W-1:0]   out_idx_q, out_idx_d;
   logic               out_last_q, out_last_d;
   logic               done_q, done_d;

   // Next-state, index, snapshot capture and registered-output decode.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         snap_d[i] = snap_q[i];
      end

      unique case (state_q)
         IDLE: begin
            if (load) begin
               for (int unsigned i = 0; i < DEPTH; i++) begin
                  snap_d[i] = load_data[i*BITS +: BITS];
               end
               idx_d   = '0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            // out_valid is high throughout STREAM, so ready alone means a transfer
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            idx_d   = '0;
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
         end
      endcase

      // Abort outranks load and transfer; snapshot contents are kept as-is.
      if (flush) begin
         state_d = IDLE;
         idx_d   = '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            snap_d[i] = snap_q[i];
         end
      end

      // Outputs are decoded from the next state so they register alongside it.
      busy_d      = (state_d != IDLE);
      out_valid_d = (state_d == STREAM);
      out_last_d  = (state_d == STREAM) && (idx_d == LAST_IDX);
      done_d      = (state_d == DONE);
      out_idx_d   = idx_d;
      out_data_d  = snap_d[idx_d];
   end

   // State, snapshot and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            snap_q[i] <= '0;
         end
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            snap_q[i] <= snap_d[i];
         end
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;
   assign done      = done_q;

`ifdef FIFO_READER_PARITY_EN
   // Parity of the presented entry, forced low whenever nothing is presented.
   assign out_parity = out_valid_q & (^out_data_q);
`endif

endmodule : fifo_reader

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a transaction-level model pushes expected beats into
// a scoreboard queue on every accepted load; a negedge monitor pops on each
// handshake and checks status outputs every cycle.
module tb_fifo_reader;

   localparam int D = 8;
   localparam int B = 64;

   typedef struct {
      logic [B-1:0] data;
      int           idx;
      logic         last;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              load = 1'b0;
   logic [D*B-1:0]    load_data = '0;
   logic              flush = 1'b0;
   logic              busy;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [B-1:0]      out_data;
   logic [2:0]        out_idx;
   logic              out_last;
   logic              done;
`ifdef FIFO_READER_PARITY_EN
   logic              out_parity;
`endif

   int    errors = 0;
   int    checks = 0;
   beat_t exp_q[$];
   int    m_left = 0;   // beats of the current snapshot not yet transferred
   bit    m_done = 1'b0; // the cycle right after the final transfer

   fifo_reader #(.DEPTH(D), .BITS(B)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .load_data (load_data),
      .flush     (flush),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .done      (done)
`ifdef FIFO_READER_PARITY_EN
      ,
      .out_parity(out_parity)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: snapshot accepted only when nothing is outstanding.
   task automatic model_step();
      if (flush) begin
         exp_q.delete();
         m_left = 0;
         m_done = 1'b0;
      end else if (m_left == 0 && !m_done) begin
         if (load) begin
            for (int i = 0; i < D; i++) begin
               beat_t b;
               b.data = load_data[i*B +: B];
               b.idx  = i;
               b.last = (i == D - 1);
               exp_q.push_back(b);
            end
            m_left = D;
         end
      end else if (m_done) begin
         m_done = 1'b0;
      end else if (out_ready) begin
         m_left--;
         if (m_left == 0) m_done = 1'b1;
      end
   endtask

   // One clock: update the model with the sampled inputs, then clear pulses.
   task automatic tick();
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      load  = 1'b0;
      flush = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((m_left > 0 || m_done) && n < 200) begin
         tick();
         n++;
      end
      checks++;
      if (m_left > 0 || m_done) begin
         errors++;
         $display("FAIL %s: drain did not finish within 200 cycles", name);
      end
   endtask

   task automatic fill_seq(input logic [B-1:0] base);
      for (int i = 0; i < D; i++) load_data[i*B +: B] = base + B'(i);
   endtask

   task automatic fill_rand();
      for (int i = 0; i < D; i++) load_data[i*B +: B] = {$urandom, $urandom};
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " busy"},      64'(busy),      64'd0);
      chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, " out_data"},  64'(out_data),  64'd0);
      chk({tag, " out_idx"},   64'(out_idx),   64'd0);
      chk({tag, " out_last"},  64'(out_last),  64'd0);
      chk({tag, " done"},      64'(done),      64'd0);
`ifdef FIFO_READER_PARITY_EN
      chk({tag, " out_parity"}, 64'(out_parity), 64'd0);
`endif
   endtask

   // Monitor: status every cycle, beat contents against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("busy",      64'(busy),      64'(m_left > 0 || m_done));
         chk("out_valid", 64'(out_valid), 64'(m_left > 0));
         chk("done",      64'(done),      64'(m_done));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL beat: valid with data 0x%0h but no entry expected", out_data);
            end else begin
               chk("out_data", 64'(out_data), 64'(exp_q[0].data));
               chk("out_idx",  64'(out_idx),  64'(exp_q[0].idx));
               chk("out_last", 64'(out_last), 64'(exp_q[0].last));
`ifdef FIFO_READER_PARITY_EN
               chk("out_parity", 64'(out_parity), 64'(^exp_q[0].data));
`endif
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      int n;
      // Reset: outputs cleared
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Straight drain of 0x10..0x17
      fill_seq(64'h10);
      out_ready = 1'b1;
      load = 1'b1;
      tick();
      drain("seq");
      repeat (2) tick();

      // Backpressure pattern 1,0,0,1 repeating
      load = 1'b1;
      tick();
      n = 0;
      while ((m_left > 0 || m_done) && n < 200) begin
         out_ready = (n % 4 == 0) || (n % 4 == 3);
         tick();
         n++;
      end
      chk("toggle drain finished", 64'(m_left > 0 || m_done), 64'd0);
      out_ready = 1'b1;
      repeat (2) tick();

      // Load during STREAM is ignored; entries 0x1 and 0x3 exercise parity
      fill_rand();
      load_data[0 +: B] = 64'h1;
      load_data[B +: B] = 64'h3;
      out_ready = 1'b0;
      load = 1'b1;
      tick();
      tick();
      fill_rand();
      load = 1'b1;
      tick();
      out_ready = 1'b1;
      tick();
      load = 1'b1;
      drain("ignored load");
      repeat (2) tick();

      // Flush at idx 3, then a fresh load streams from index 0
      fill_seq(64'h100);
      load = 1'b1;
      tick();
      n = 0;
      while (m_left > 5 && n < 50) begin tick(); n++; end
      chk("flush reached idx", 64'(out_idx), 64'd3);
      flush = 1'b1;
      tick();
      repeat (3) tick();
      fill_seq(64'h200);
      load = 1'b1;
      flush = 1'b1;
      tick();
      chk("load+flush stays idle", 64'(busy), 64'd0);
      load = 1'b1;
      tick();
      drain("after flush");
      repeat (2) tick();

      // Asynchronous reset at idx 5
      fill_seq(64'h300);
      load = 1'b1;
      tick();
      n = 0;
      while (m_left > 3 && n < 50) begin tick(); n++; end
      chk("reset reached idx", 64'(out_idx), 64'd5);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_all_zero("midstream reset");
      exp_q.delete();
      m_left = 0;
      m_done = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      fill_seq(64'h400);
      load = 1'b1;
      tick();
      drain("after reset");
      repeat (2) tick();

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         fill_rand();
         load      = ($urandom_range(0, 5) == 0);
         flush     = ($urandom_range(0, 40) == 0);
         out_ready = $urandom_range(0, 3) != 0;
         tick();
      end
      out_ready = 1'b1;
      drain("random");
      repeat (2) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_fifo_reader
